qspi_requester: RTL and testbench

//  Initiator side of the QSPI request/response interface; drives qspi_req_out into the QSPI manager front end.

---
 rtl/qspi_requester_pkg.sv | 32 +++
 rtl/qspi_req_timer.sv | 28 ++
 rtl/qspi_requester.sv | 162 ++++++++++++++++
 tb/tb_qspi_requester.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_requester_pkg.sv
// Shared field widths, request/response packing and FSM state encoding
// for the QSPI requester and its helpers.
package qspi_requester_pkg;

    localparam int QSPI_CMD_LEN   = 8;
    localparam int QSPI_ADDR_LEN  = 24;
    localparam int QSPI_WDATA_LEN = 32;
    localparam int QSPI_RDATA_LEN = 32;

    // Request bus is {cmd, addr, wdata, start}; response bus is {rdata, idle}
    localparam int QSPI_REQ_WIDTH = QSPI_CMD_LEN + QSPI_ADDR_LEN + QSPI_WDATA_LEN + 1;
    localparam int QSPI_RSP_WIDTH = QSPI_RDATA_LEN + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_MGR  = 3'd1,
        S_START     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    function automatic logic [QSPI_REQ_WIDTH-1:0] pack_req(
        input logic [QSPI_CMD_LEN-1:0]   cmd,
        input logic [QSPI_ADDR_LEN-1:0]  addr,
        input logic [QSPI_WDATA_LEN-1:0] wdata,
        input logic                      start
    );
        return {cmd, addr, wdata, start};
    endfunction

endpackage

// File: rtl/qspi_req_timer.sv
// Saturating cycle timer with synchronous clear, count enable and a
// terminal-count compare against a caller-selected limit.
module qspi_req_timer #(
    parameter int TMR_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMR_W-1:0] terminal,
    output logic [TMR_W-1:0] count,
    output logic             at_terminal
);

    // Count up while enabled, stick at all-ones rather than wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TMR_W'(1);
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/qspi_requester.sv
// Initiator side of the QSPI request/response interface: takes one host
// command at a time, hands it to the manager with a one-cycle start pulse,
// watches the manager idle flag for acknowledge and completion, and returns
// the captured read data with a timeout error flag.
module qspi_requester
    import qspi_requester_pkg::*;
#(
    parameter int ACK_CYCLES  = 16,
    parameter int DONE_CYCLES = 1_000_000,
    parameter int TMR_W       = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      host_valid,
    output logic                      host_ready,
    input  logic [QSPI_CMD_LEN-1:0]   host_cmd,
    input  logic [QSPI_ADDR_LEN-1:0]  host_addr,
    input  logic [QSPI_WDATA_LEN-1:0] host_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [QSPI_RDATA_LEN-1:0] rsp_rdata,
    output logic                      rsp_error,
    output logic [QSPI_REQ_WIDTH-1:0] qspi_req_out,
    input  logic [QSPI_RSP_WIDTH-1:0] qspi_rsp_in
);

    localparam logic [TMR_W-1:0] ACK_TERM  = TMR_W'(ACK_CYCLES - 1);
    localparam logic [TMR_W-1:0] DONE_TERM = TMR_W'(DONE_CYCLES - 1);

    state_t state_q, state_d;

    logic [QSPI_CMD_LEN-1:0]   cmd_q;
    logic [QSPI_ADDR_LEN-1:0]  addr_q;
    logic [QSPI_WDATA_LEN-1:0] wdata_q;

    logic                      mgr_idle;
    logic [QSPI_RDATA_LEN-1:0] mgr_rdata;

    logic             tmr_clear;
    logic             tmr_enable;
    logic [TMR_W-1:0] tmr_terminal;
    logic [TMR_W-1:0] tmr_count;
    logic             tmr_at_term;

    logic capture_ok;
    logic capture_err;

    assign mgr_idle  = qspi_rsp_in[0];
    assign mgr_rdata = qspi_rsp_in[QSPI_RSP_WIDTH-1:1];

    qspi_req_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (tmr_clear),
        .enable      (tmr_enable),
        .terminal    (tmr_terminal),
        .count       (tmr_count),
        .at_terminal (tmr_at_term)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, timer control and response capture; the ack window opens the cycle after start
    always_comb begin
        state_d      = state_q;
        tmr_clear    = 1'b0;
        tmr_enable   = 1'b0;
        tmr_terminal = ACK_TERM;
        capture_ok   = 1'b0;
        capture_err  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tmr_clear = 1'b1;
                if (host_valid) begin
                    state_d = S_WAIT_MGR;
                end
            end
            S_WAIT_MGR: begin
                if (mgr_idle) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                tmr_clear = 1'b1;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tmr_terminal = ACK_TERM;
                if (!mgr_idle) begin
                    tmr_clear = 1'b1;
                    state_d   = S_WAIT_DONE;
                end else if (tmr_at_term) begin
                    capture_err = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                tmr_terminal = DONE_TERM;
                if (mgr_idle) begin
                    capture_ok = 1'b1;
                    state_d    = S_RESP;
                end else if (tmr_at_term) begin
                    capture_err = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request fields latch on the accept edge and hold until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if ((state_q == S_IDLE) && host_valid) begin
            cmd_q   <= host_cmd;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
        end
    end

    // Response payload: manager data on completion, zero data with error on timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (capture_ok) begin
            rsp_rdata <= mgr_rdata;
            rsp_error <= 1'b0;
        end else if (capture_err) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
        end
    end

    assign host_ready   = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign qspi_req_out = pack_req(cmd_q, addr_q, wdata_q, state_q == S_START);

endmodule

// File: tb/tb_qspi_requester.sv
// Directed bench for qspi_requester: a table of transactions run against a
// small manager model, plus hand sequences for backpressure and mid-flight reset.
module tb_qspi_requester;
    import qspi_requester_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      host_valid;
    logic                      host_ready;
    logic [QSPI_CMD_LEN-1:0]   host_cmd;
    logic [QSPI_ADDR_LEN-1:0]  host_addr;
    logic [QSPI_WDATA_LEN-1:0] host_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [QSPI_RDATA_LEN-1:0] rsp_rdata;
    logic                      rsp_error;
    logic [QSPI_REQ_WIDTH-1:0] qspi_req_out;
    logic [QSPI_RSP_WIDTH-1:0] qspi_rsp_in;

    // Manager model state (written only by the model process)
    logic        mgr_idle  = 1'b1;
    logic [31:0] mgr_rdata = 32'h0;
    int          pre_cnt   = 0;
    int          busy_cnt  = 0;
    int          seen_gen  = 0;

    // Manager model configuration (written only by the test process)
    int          cfg_gen    = 0;
    int          cfg_pre    = 0;
    int          cfg_busy   = 0;
    logic [31:0] cfg_rdata  = 32'h0;
    bit          cfg_ignore = 1'b0;
    bit          cfg_hang   = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] wdata;
        int          pre_busy;
        int          busy;
        logic [31:0] rdata;
        bit          ignore;
        bit          hang;
        logic [31:0] exp_rdata;
        bit          exp_error;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    assign qspi_rsp_in = {mgr_rdata, mgr_idle};

    qspi_requester #(
        .ACK_CYCLES  (16),
        .DONE_CYCLES (100),
        .TMR_W       (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_cmd     (host_cmd),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .qspi_req_out (qspi_req_out),
        .qspi_rsp_in  (qspi_rsp_in)
    );

    always #5 clk = ~clk;

    // Manager model: optional busy period before the command, idle drops the cycle after
    // start, stays low for cfg_busy cycles, then rises with read data (unless ignoring or hung)
    always @(negedge clk) begin
        if (cfg_gen != seen_gen) begin
            seen_gen  = cfg_gen;
            busy_cnt  = 0;
            mgr_rdata = 32'h5555AAAA;
            pre_cnt   = cfg_pre;
            mgr_idle  = (cfg_pre == 0);
        end else if (pre_cnt > 0) begin
            pre_cnt = pre_cnt - 1;
            if (pre_cnt == 0) mgr_idle = 1'b1;
        end else if ((qspi_req_out[0] === 1'b1) && !cfg_ignore) begin
            mgr_idle  = 1'b0;
            busy_cnt  = cfg_busy + 1;
            mgr_rdata = 32'hDEADBEEF;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if ((busy_cnt == 0) && !cfg_hang) begin
                mgr_idle  = 1'b1;
                mgr_rdata = cfg_rdata;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one command, program the model, and wait (bounded) for rsp_valid
    task automatic issue_wait(input vec_t v, output int lat, output int starts, output int hold_bad);
        @(posedge clk);
        #1;
        cfg_pre    = v.pre_busy;
        cfg_busy   = v.busy;
        cfg_rdata  = v.rdata;
        cfg_ignore = v.ignore;
        cfg_hang   = v.hang;
        cfg_gen    = cfg_gen + 1;
        host_valid = 1'b1;
        host_cmd   = v.cmd;
        host_addr  = v.addr;
        host_wdata = v.wdata;
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        lat      = -1;
        starts   = 0;
        hold_bad = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (qspi_req_out[0] === 1'b1) starts++;
            if (qspi_req_out[QSPI_REQ_WIDTH-1:1] !== {v.cmd, v.addr, v.wdata}) hold_bad++;
            if (host_ready !== 1'b0) hold_bad++;
            if (rsp_valid === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    // Complete the response handshake and confirm the requester is ready again
    task automatic do_handshake(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_output({name, " rsp_valid after handshake"}, 64'(rsp_valid), 64'd0);
        check_output({name, " host_ready after handshake"}, 64'(host_ready), 64'd1);
    endtask

    task automatic apply_stimulus(input int idx);
        int    lat, starts, hold_bad;
        string nm;
        nm = $sformatf("vec%0d", idx);
        issue_wait(vecs[idx], lat, starts, hold_bad);
        check_output({nm, " latency"}, 64'(lat), 64'(vecs[idx].exp_lat));
        check_output({nm, " start pulses"}, 64'(starts), 64'd1);
        check_output({nm, " fields held"}, 64'(hold_bad), 64'd0);
        check_output({nm, " rdata"}, 64'(rsp_rdata), 64'(vecs[idx].exp_rdata));
        check_output({nm, " error"}, 64'(rsp_error), 64'(vecs[idx].exp_error));
        do_handshake(nm);
    endtask

    initial begin
        int   lat, starts, hold_bad, stable_bad, spurious;
        vec_t v;

        //           cmd    addr        wdata         pre busy rdata         ign hang exp_rdata     err lat
        vecs[0] = '{8'h6B, 24'h001000, 32'h00000000, 0,  8, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0, 11};
        vecs[1] = '{8'h02, 24'h00ABCD, 32'h12345678, 50, 3, 32'h11223344, 0, 0, 32'h11223344, 0, 55};
        vecs[2] = '{8'h03, 24'h000200, 32'h00000000, 0,  0, 32'h77777777, 1, 0, 32'h00000000, 1, 18};
        vecs[3] = '{8'h0B, 24'h0F0000, 32'h00000000, 0,  0, 32'h88888888, 0, 1, 32'h00000000, 1, 103};
        vecs[4] = '{8'h05, 24'h000004, 32'h00000000, 0,  1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 4};
        vecs[5] = '{8'h32, 24'h123456, 32'h87654321, 0,  2, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 5};

        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = '0;
        host_addr  = '0;
        host_wdata = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset host_ready", 64'(host_ready), 64'd1);
        check_output("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset rsp_error", 64'(rsp_error), 64'd0);
        check_output("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_output("reset req_out", 64'(qspi_req_out[63:0]) | 64'(qspi_req_out[64]), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(i);
        end

        // Backpressure: response held 20 cycles while a second command waits
        v = '{8'h9F, 24'h00F00F, 32'h0000BEEF, 0, 2, 32'h5A5A0001, 0, 0, 32'h5A5A0001, 0, 5};
        issue_wait(v, lat, starts, hold_bad);
        check_output("bp latency", 64'(lat), 64'd5);
        host_valid = 1'b1;
        host_cmd   = 8'hC7;
        host_addr  = 24'h00C0DE;
        host_wdata = 32'h01020304;
        stable_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1) stable_bad++;
            if (rsp_rdata !== 32'h5A5A0001) stable_bad++;
            if (rsp_error !== 1'b0) stable_bad++;
            if (host_ready !== 1'b0) stable_bad++;
            if (qspi_req_out[0] !== 1'b0) stable_bad++;
            if (qspi_req_out[QSPI_REQ_WIDTH-1:1] !== {8'h9F, 24'h00F00F, 32'h0000BEEF}) stable_bad++;
        end
        check_output("bp hold stable", 64'(stable_bad), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready  = 1'b0;
        cfg_pre    = 0;
        cfg_busy   = 1;
        cfg_rdata  = 32'h0000C7C7;
        cfg_ignore = 1'b0;
        cfg_hang   = 1'b0;
        cfg_gen    = cfg_gen + 1;
        @(negedge clk);
        check_output("bp released rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("bp released host_ready", 64'(host_ready), 64'd1);
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        @(negedge clk);
        check_output("bp 2nd accepted host_ready", 64'(host_ready), 64'd0);
        check_output("bp 2nd cmd field", 64'(qspi_req_out[QSPI_REQ_WIDTH-1:QSPI_REQ_WIDTH-8]), 64'hC7);
        lat = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_output("bp 2nd response seen", 64'(lat >= 0), 64'd1);
        check_output("bp 2nd rdata", 64'(rsp_rdata), 64'h0000C7C7);
        do_handshake("bp2");

        // Reset while waiting for completion
        v = '{8'hAB, 24'h000010, 32'h00000000, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0};
        @(posedge clk);
        #1;
        cfg_pre    = 0;
        cfg_busy   = 0;
        cfg_ignore = 1'b0;
        cfg_hang   = 1'b1;
        cfg_gen    = cfg_gen + 1;
        host_valid = 1'b1;
        host_cmd   = v.cmd;
        host_addr  = v.addr;
        host_wdata = v.wdata;
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_output("rst pre busy host_ready", 64'(host_ready), 64'd0);
        reset = 1'b1;
        #1;
        check_output("rst start", 64'(qspi_req_out[0]), 64'd0);
        check_output("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rst host_ready", 64'(host_ready), 64'd1);
        check_output("rst cmd field", 64'(qspi_req_out[QSPI_REQ_WIDTH-1:QSPI_REQ_WIDTH-8]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cfg_hang = 1'b0;
        cfg_gen  = cfg_gen + 1;
        spurious = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) spurious++;
            if (qspi_req_out[0] !== 1'b0) spurious++;
        end
        check_output("rst no spurious activity", 64'(spurious), 64'd0);
        apply_stimulus(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
